square_seq: RTL

SQUARE_SEQ -- requirements
Module: square_seq

---
 rtl/square_seq_pkg.sv | 16 +
 rtl/square_step.sv | 28 ++
 rtl/square_seq.sv | 117 +++++++++++
 3 files changed

// File: rtl/square_seq_pkg.sv
// rtl/square_seq_pkg.sv - shared definitions for the sequential squarer
//
// Contents:
//   LEN_DEFAULT : default result width (operand width is half of it)
//   state_e     : FSM state encoding, IDLE = 0, BUSY = 1, DONE = 2
package square_seq_pkg;

    localparam int LEN_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/square_step.sv
// rtl/square_step.sv - one shift-add iteration of the sequential squarer
//
// Ports:
//   acc     : running accumulator (LEN bits)
//   a       : latched operand (RLEN bits)
//   m0      : current multiplier bit
//   cnt     : iteration index, i.e. shift amount for this step
//   acc_nxt : accumulator after this step
module square_step #(
    parameter int LEN  = 16,
    parameter int RLEN = LEN / 2,
    parameter int CW   = 3
) (
    input  logic [LEN-1:0]  acc,
    input  logic [RLEN-1:0] a,
    input  logic            m0,
    input  logic [CW-1:0]   cnt,
    output logic [LEN-1:0]  acc_nxt
);

    logic [LEN-1:0] a_ext;

    always_comb begin
        a_ext   = {{(LEN - RLEN){1'b0}}, a};
        acc_nxt = m0 ? (acc + (a_ext << cnt)) : acc;
    end

endmodule

// File: rtl/square_seq.sv
// rtl/square_seq.sv - sequential shift-add squarer, Y = X*X in RLEN cycles
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid, in_ready  : operand handshake (in_ready high only in IDLE)
//   X                   : unsigned operand, RLEN = LEN/2 bits
//   out_valid, out_ready: result handshake (out_valid high only in DONE)
//   Y                   : unsigned result, LEN bits
module square_seq
    import square_seq_pkg::*;
#(
    parameter int LEN = LEN_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [LEN/2-1:0]    X,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LEN-1:0]      Y
);

    localparam int RLEN = LEN / 2;
    localparam int CW   = $clog2(RLEN);

    state_e          state_q, state_d;
    logic [RLEN-1:0] a_q, a_d;
    logic [RLEN-1:0] m_q, m_d;
    logic [LEN-1:0]  acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [LEN-1:0]  acc_step;

    square_step #(
        .LEN  (LEN),
        .RLEN (RLEN),
        .CW   (CW)
    ) u_step (
        .acc     (acc_q),
        .a       (a_q),
        .m0      (m_q[0]),
        .cnt     (cnt_q),
        .acc_nxt (acc_step)
    );

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        m_d         = m_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                // in_ready is high throughout IDLE, so in_valid alone is the accept.
                if (in_valid) begin
                    state_d    = BUSY;
                    a_d        = X;
                    m_d        = X;
                    acc_d      = '0;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                end
            end
            BUSY: begin
                // Fixed RLEN iterations: no early exit when M runs out of ones.
                acc_d = acc_step;
                m_d   = m_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(RLEN - 1)) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            m_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            m_q         <= m_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign Y         = acc_q;

endmodule
